// File: rtl/rs_syndrome_if.sv
// rs_syndrome_if: symbol-stream input and syndrome-result output bundle for rs_syndrome.
// The master drives the received symbol stream; the slave (rs_syndrome) returns the syndromes.
interface rs_syndrome_if #(
    parameter int unsigned NSYN = 30
);
    logic                   sop;
    logic                   valid_in;
    logic [9:0]             data_in;
    logic                   syn_valid;
    logic [10*NSYN-1:0]     syn_out;
    logic                   syn_nz;
    logic                   frame_abort;
    logic                   busy;
    logic [15:0]            err_frames;

    modport master (
        output sop, valid_in, data_in,
        input  syn_valid, syn_out, syn_nz, frame_abort, busy, err_frames
    );

    modport slave (
        input  sop, valid_in, data_in,
        output syn_valid, syn_out, syn_nz, frame_abort, busy, err_frames
    );
endinterface

// File: rtl/rs_syndrome.sv
// rs_syndrome: syndrome front end of the RS(544,514) decoder over GF(2^10), x^10+x^3+1.
// Accumulates S_j = r(alpha^j), j = 0..NSYN-1, by Horner's rule, one symbol per valid cycle,
// highest-degree coefficient first. Completed syndromes land in a separate output register.
// Optional build macro RS_SYN_ERRCNT_EN: saturating 16-bit count of frames with nonzero
// syndromes on err_frames; when undefined err_frames is tied to zero.
module rs_syndrome #(
    parameter int unsigned N    = 544,
    parameter int unsigned NSYN = 30
) (
    input logic          clk,
    input logic          rst,
    rs_syndrome_if.slave bus
);

    localparam int unsigned W       = 10;
    // Reduction term of x^10 = x^3 + 1.
    localparam logic [W-1:0] PolyLow = 10'h009;
    localparam logic [W-1:0] LastIdx = W'(N - 1);

    typedef logic [NSYN-1:0][W-1:0] syn_vec_t;

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } state_e;

    // One multiply by alpha: shift left, fold x^10 back as x^3 + 1.
    function automatic logic [W-1:0] mul_alpha(input logic [W-1:0] x);
        return {x[W-2:0], 1'b0} ^ ({W{x[W-1]}} & PolyLow);
    endfunction

    // Multiply by alpha^p; p is a constant per syndrome lane, so this collapses to an XOR net.
    function automatic logic [W-1:0] mul_alpha_pow(input logic [W-1:0] x,
                                                   input int unsigned p);
        logic [W-1:0] y;
        y = x;
        for (int unsigned k = 0; k < NSYN; k++) begin
            if (k < p) begin
                y = mul_alpha(y);
            end
        end
        return y;
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    syn_vec_t       acc_q, acc_d;
    syn_vec_t       syn_q, syn_d;
    logic           nz_q, nz_d;
    logic           syn_valid_q, syn_valid_d;
    logic           abort_q, abort_d;

    syn_vec_t       acc_upd;
    syn_vec_t       acc_load;

    // Horner step for every lane: S_j * alpha^j xor r, plus the sop reload value.
    always_comb begin
        acc_upd  = '0;
        acc_load = '0;
        for (int unsigned j = 0; j < NSYN; j++) begin
            acc_upd[j]  = mul_alpha_pow(acc_q[j], j) ^ bus.data_in;
            acc_load[j] = bus.data_in;
        end
    end

    // Frame FSM: next state, counter, accumulators, output register and pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        syn_d       = syn_q;
        nz_d        = nz_q;
        syn_valid_d = 1'b0;
        abort_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Symbols without sop are dropped while idle.
                if (bus.valid_in && bus.sop) begin
                    acc_d   = acc_load;
                    cnt_d   = W'(1);
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (bus.valid_in) begin
                    if (bus.sop) begin
                        // New frame interrupts the current one; its partial sums are lost.
                        abort_d = 1'b1;
                        acc_d   = acc_load;
                        cnt_d   = W'(1);
                    end else begin
                        acc_d = acc_upd;
                        if (cnt_q == LastIdx) begin
                            // Final symbol: publish the combinational result directly.
                            syn_d       = acc_upd;
                            nz_d        = |acc_upd;
                            syn_valid_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = StIdle;
                        end else begin
                            cnt_d = cnt_q + W'(1);
                        end
                    end
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            syn_q       <= '0;
            nz_q        <= 1'b0;
            syn_valid_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            syn_q       <= syn_d;
            nz_q        <= nz_d;
            syn_valid_q <= syn_valid_d;
            abort_q     <= abort_d;
        end
    end

`ifdef RS_SYN_ERRCNT_EN
    logic [15:0] err_q, err_d;

    // Errored-frame counter, updated on the same edge that publishes the frame; saturates.
    always_comb begin
        err_d = err_q;
        if (syn_valid_d && nz_d && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_frames = err_q;
`else
    assign bus.err_frames = 16'h0000;
`endif

    assign bus.syn_valid   = syn_valid_q;
    assign bus.syn_out     = syn_q;
    assign bus.syn_nz      = nz_q;
    assign bus.frame_abort = abort_q;
    assign bus.busy        = (state_q == StAccum);

endmodule

// File: tb/tb_rs_syndrome.sv
// tb_rs_syndrome: scoreboard bench for rs_syndrome. The driver pushes expected syndrome
// results and abort pulses with their due cycle; an independent monitor pops and compares.
module tb_rs_syndrome;

    localparam int NLEN = 544;
    localparam int NS   = 30;

    // alpha^j in GF(2^10) mod x^10+x^3+1, worked out by hand.
    localparam logic [9:0] ALPHA_TAB [30] = '{
        10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080,
        10'h100, 10'h200, 10'h009, 10'h012, 10'h024, 10'h048, 10'h090, 10'h120,
        10'h240, 10'h089, 10'h112, 10'h224, 10'h041, 10'h082, 10'h104, 10'h208,
        10'h019, 10'h032, 10'h064, 10'h0C8, 10'h190, 10'h320
    };

    typedef struct {
        logic [299:0] syn;
        logic         nz;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_syndrome_if #(.NSYN(NS)) bus ();

    rs_syndrome #(.N(NLEN), .NSYN(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         errors  = 0;
    int         checks  = 0;
    int         drv_cyc = 0;
    int         mon_cyc = 0;
    int         nerr    = 0;
    exp_t       exp_q[$];
    int         abort_q[$];
    logic [9:0] frm [NLEN];
    logic [9:0] g [31];

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] p;
        p = '0;
        for (int i = 9; i >= 0; i--) begin
            p = {p[8:0], 1'b0} ^ (p[9] ? 10'h009 : 10'h000);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    function automatic logic [299:0] all_same(input logic [9:0] v);
        logic [299:0] r;
        for (int j = 0; j < NS; j++) r[10*j +: 10] = v;
        return r;
    endfunction

    function automatic logic [299:0] alpha_vec();
        logic [299:0] r;
        for (int j = 0; j < NS; j++) r[10*j +: 10] = ALPHA_TAB[j];
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        drv_cyc++;
    endtask

    task automatic idle();
        tick();
        bus.valid_in = 1'b0;
        bus.sop      = 1'b0;
        bus.data_in  = 10'($urandom);
    endtask

    task automatic send_sym(input logic s, input logic [9:0] d);
        tick();
        bus.valid_in = 1'b1;
        bus.sop      = s;
        bus.data_in  = d;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < NLEN; i++) frm[i] = '0;
    endtask

    // Add s * x^k * g(x); index i of the frame holds the coefficient of x^(543-i).
    task automatic add_gen(input int k, input logic [9:0] s);
        for (int d = 0; d <= 30; d++) frm[NLEN-1-(k+d)] ^= gf_mul(s, g[d]);
    endtask

    task automatic send_frame(input logic [299:0] esyn, input logic enz, input int nsym,
                              input int gap_max, input logic aborting, input string name);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < nsym; i++) begin
            if (i > 0 && gap_max > 0) begin
                repeat ($urandom_range(1, gap_max)) begin
                    idle();
                    if (bus.busy !== 1'b1) bad = 1'b1;
                end
            end
            send_sym(i == 0, frm[i]);
            if (i > 0 && bus.busy !== 1'b1) bad = 1'b1;
            if (i == 0 && aborting) abort_q.push_back(drv_cyc + 1);
            if (i == NLEN - 1) begin
                exp_q.push_back('{syn: esyn, nz: enz, cyc: drv_cyc + 1});
                if (enz) nerr++;
            end
        end
        chk({name, " busy"}, {299'b0, bad}, 300'b0);
    endtask

    // Monitor: compare every syn_valid / frame_abort pulse against the scoreboard.
    initial begin
        exp_t e;
        int   ac;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (bus.syn_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected syn_valid", 300'd1, 300'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("syn_out", bus.syn_out, e.syn);
                    chk("syn_nz", {299'b0, bus.syn_nz}, {299'b0, e.nz});
                    chk("syn_valid cycle", 300'(mon_cyc), 300'(e.cyc));
                end
            end
            if (bus.frame_abort === 1'b1) begin
                if (abort_q.size() == 0) begin
                    chk("unexpected frame_abort", 300'd1, 300'd0);
                end else begin
                    ac = abort_q.pop_front();
                    chk("frame_abort cycle", 300'(mon_cyc), 300'(ac));
                end
            end
        end
    end

    task automatic check_errcnt(input string name);
`ifdef RS_SYN_ERRCNT_EN
        chk(name, {284'b0, bus.err_frames}, 300'(nerr));
`else
        chk(name, {284'b0, bus.err_frames}, 300'd0);
`endif
    endtask

    initial begin
        // Generator g(x) = prod (x + alpha^j), j = 0..29; its multiples are codewords.
        for (int d = 0; d <= 30; d++) g[d] = '0;
        g[0] = 10'h001;
        for (int j = 0; j < NS; j++) begin
            for (int d = 30; d >= 0; d--) begin
                g[d] = ((d > 0) ? g[d-1] : 10'h000) ^ gf_mul(g[d], ALPHA_TAB[j]);
            end
        end

        rst          = 1'b1;
        bus.sop      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        repeat (3) tick();
        chk("reset syn_out", bus.syn_out, 300'd0);
        chk("reset syn_nz", {299'b0, bus.syn_nz}, 300'd0);
        chk("reset syn_valid", {299'b0, bus.syn_valid}, 300'd0);
        chk("reset frame_abort", {299'b0, bus.frame_abort}, 300'd0);
        chk("reset busy", {299'b0, bus.busy}, 300'd0);
        chk("reset err_frames", {284'b0, bus.err_frames}, 300'd0);
        tick();
        rst = 1'b0;

        // Stray symbols while idle must be dropped.
        repeat (3) send_sym(1'b0, 10'($urandom));
        idle();
        chk("stray busy", {299'b0, bus.busy}, 300'd0);

        // All-zero frame.
        clear_frame();
        send_frame(300'd0, 1'b0, NLEN, 0, 1'b0, "zero");
        idle();

        // Single error in x^0 coefficient: every S_j equals it.
        clear_frame();
        frm[543] = 10'h2A5;
        send_frame(all_same(10'h2A5), 1'b1, NLEN, 0, 1'b0, "err543");

        // Single 1 in x^1 coefficient: S_j = alpha^j (back-to-back with the previous).
        clear_frame();
        frm[542] = 10'h001;
        send_frame(alpha_vec(), 1'b1, NLEN, 0, 1'b0, "err542");

        // Five codewords back-to-back.
        clear_frame();
        add_gen(0, 10'h001);
        send_frame(300'd0, 1'b0, NLEN, 0, 1'b0, "cw1");
        clear_frame();
        add_gen(513, 10'h3FF);
        send_frame(300'd0, 1'b0, NLEN, 0, 1'b0, "cw2");
        clear_frame();
        add_gen(0, 10'h155);
        add_gen(100, 10'h0F0);
        add_gen(250, 10'h3C7);
        add_gen(513, 10'h011);
        send_frame(300'd0, 1'b0, NLEN, 0, 1'b0, "cw3");
        clear_frame();
        for (int k = 0; k <= 513; k += 17) add_gen(k, 10'(k * 37 + 5));
        send_frame(300'd0, 1'b0, NLEN, 0, 1'b0, "cw4");
        clear_frame();
        add_gen(256, 10'h2A5);
        add_gen(3, 10'h007);
        send_frame(300'd0, 1'b0, NLEN, 0, 1'b0, "cw5");

        // Gapped codeword, then gapped codeword plus an x^0 error.
        send_frame(300'd0, 1'b0, NLEN, 5, 1'b0, "gap cw");
        frm[543] ^= 10'h13C;
        send_frame(all_same(10'h13C), 1'b1, NLEN, 5, 1'b0, "gap err");
        frm[543] ^= 10'h13C;
        idle();

        // Abort at symbol 100, then a full codeword.
        send_frame(300'd0, 1'b0, 100, 0, 1'b0, "abort head");
        clear_frame();
        add_gen(40, 10'h0AB);
        add_gen(400, 10'h301);
        send_frame(300'd0, 1'b0, NLEN, 0, 1'b1, "abort cw");
        repeat (3) idle();
        check_errcnt("err_frames");

        // Reset at symbol 300 discards the frame and clears everything.
        frm[543] ^= 10'h0FF;
        send_frame(300'd0, 1'b0, 300, 0, 1'b0, "rst head");
        tick();
        bus.valid_in = 1'b0;
        bus.sop      = 1'b0;
        rst          = 1'b1;
        tick();
        rst  = 1'b0;
        nerr = 0;
        tick();
        chk("midrst syn_out", bus.syn_out, 300'd0);
        chk("midrst syn_nz", {299'b0, bus.syn_nz}, 300'd0);
        chk("midrst busy", {299'b0, bus.busy}, 300'd0);
        chk("midrst err_frames", {284'b0, bus.err_frames}, 300'd0);

        // Recovery after reset.
        clear_frame();
        frm[543] = 10'h001;
        send_frame(all_same(10'h001), 1'b1, NLEN, 0, 1'b0, "post rst");
        repeat (4) idle();
        check_errcnt("err_frames final");
        chk("pending syn_valid", 300'(exp_q.size()), 300'd0);
        chk("pending frame_abort", 300'(abort_q.size()), 300'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
